// File: rtl/x_dl_edge_stats.sv
// Edge-position statistics for the 128-tap delay line: popcount of each
// registered tap word, with min/max/sum/avg accumulated over a 2^k window.
module x_dl_edge_stats #(
  parameter int TAPS     = 128,
  parameter int MAX_LOG2 = 15
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [TAPS-1:0] i_dl,
  input  logic [31:0]     i_ctrl,
  output logic [31:0]     o_data,
  output logic            o_busy
);

  localparam int CW = $clog2(TAPS + 1);
  localparam int SW = CW + MAX_LOG2;
  localparam int KW = $clog2(MAX_LOG2 + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [CW-1:0] popcount(input logic [TAPS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < TAPS; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  logic [TAPS-1:0] taps_q;
  logic [CW-1:0]   pop_q,   pop_d;
  logic            start_q;
  state_e          state_q, state_d;
  logic            flush_q, flush_d;
  logic [KW-1:0]   k_q,     k_d;
  logic [CW-1:0]   min_q,   min_d;
  logic [CW-1:0]   max_q,   max_d;
  logic [SW-1:0]   sum_q,   sum_d;
  logic [15:0]     count_q, count_d;
  logic [31:0]     data_q,  data_d;

  logic            start_p_s;
  logic            clear_s;
  logic [3:0]      k_raw_s;
  logic [KW-1:0]   k_sel_s;
  logic [16:0]     target_s;
  logic [16:0]     count_inc_s;
  logic [CW-1:0]   avg_s;
  logic            ctrl_unused_s;

  assign ctrl_unused_s = ^{i_ctrl[31:10], i_ctrl[3], i_ctrl[0]};

  // Control decode, window clamp and FSM next-state / accumulator update.
  always_comb begin
    start_p_s   = i_ctrl[1] & ~start_q;
    clear_s     = i_ctrl[2];
    k_raw_s     = i_ctrl[7:4];
    target_s    = 17'd1 << k_q;
    count_inc_s = {1'b0, count_q} + 17'd1;
    pop_d       = popcount(taps_q);

    if (32'(k_raw_s) > MAX_LOG2) begin
      k_sel_s = KW'(MAX_LOG2);
    end else begin
      k_sel_s = KW'(k_raw_s);
    end

    state_d = state_q;
    flush_d = flush_q;
    k_d     = k_q;
    min_d   = min_q;
    max_d   = max_q;
    sum_d   = sum_q;
    count_d = count_q;

    if (clear_s) begin
      state_d = IDLE;
      flush_d = 1'b0;
      min_d   = '0;
      max_d   = '0;
      sum_d   = '0;
      count_d = 16'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_p_s) begin
            state_d = FLUSH;
            flush_d = 1'b0;
            k_d     = k_sel_s;
            min_d   = '1;
            max_d   = '0;
            sum_d   = '0;
            count_d = 16'd0;
          end else begin
            state_d = state_q;
          end
        end
        // Two cycles let pop_q catch up with samples taken after the start edge.
        FLUSH: begin
          if (flush_q) begin
            state_d = RUN;
            flush_d = 1'b0;
          end else begin
            flush_d = 1'b1;
          end
        end
        RUN: begin
          sum_d   = sum_q + SW'(pop_q);
          count_d = count_inc_s[15:0];
          if (pop_q < min_q) begin
            min_d = pop_q;
          end else begin
            min_d = min_q;
          end
          if (pop_q > max_q) begin
            max_d = pop_q;
          end else begin
            max_d = max_q;
          end
          if (count_inc_s == target_s) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Readback mux; the selected word is registered before leaving the block.
  always_comb begin
    avg_s = CW'(sum_q >> k_q);
    case (i_ctrl[9:8])
      2'd0:    data_d = {state_q, 6'd0, 8'(avg_s), 8'd0, 8'(pop_q)};
      2'd1:    data_d = {8'd0, 8'(min_q), 8'd0, 8'(max_q)};
      2'd2:    data_d = 32'(sum_q);
      2'd3:    data_d = 32'(count_q);
      default: data_d = 32'd0;
    endcase
  end

  // State, pipeline and readback registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      taps_q  <= '0;
      pop_q   <= '0;
      start_q <= 1'b0;
      state_q <= IDLE;
      flush_q <= 1'b0;
      k_q     <= '0;
      min_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
      count_q <= 16'd0;
      data_q  <= 32'd0;
    end else begin
      taps_q  <= i_dl;
      pop_q   <= pop_d;
      start_q <= i_ctrl[1];
      state_q <= state_d;
      flush_q <= flush_d;
      k_q     <= k_d;
      min_q   <= min_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign o_data = data_q;
  assign o_busy = (state_q == FLUSH) || (state_q == RUN);

endmodule

// File: tb/tb_x_dl_edge_stats.sv
// Randomized scoreboard bench for x_dl_edge_stats: expected words are queued
// with the edge they are due at, and a negedge monitor pops and compares them.
module tb_x_dl_edge_stats;

  localparam int SAMP_N = 60000;

  logic         clk = 1'b0;
  logic         i_rst;
  logic [127:0] i_dl;
  logic [31:0]  i_ctrl;
  logic [31:0]  o_data;
  logic         o_busy;

  x_dl_edge_stats dut (
    .i_clk  (clk),
    .i_rst  (i_rst),
    .i_dl   (i_dl),
    .i_ctrl (i_ctrl),
    .o_data (o_data),
    .o_busy (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          due;
    int          kind;   // 0 o_data, 1 o_busy, 2 busy-cycle count
    logic [31:0] exp;
    logic [31:0] mask;
    int          base;
  } sb_t;

  sb_t  sb[$];
  int   edge_n     = 0;
  int   busy_total = 0;
  int   checks     = 0;
  int   failures   = 0;
  int   samp [0:SAMP_N-1];

  int         dl_mode = 0;  // 0 random, 1 fixed count, 2 alternate 10/20, 3 all ones
  int         dl_n    = 0;
  bit         alt_ph  = 1'b0;
  logic [1:0] sel_v   = 2'd0;
  logic [3:0] k_v     = 4'd0;
  logic       clr_v   = 1'b0;
  logic       start_v = 1'b0;

  // Record the edge position the DUT sees at every rising edge.
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (edge_n < SAMP_N) samp[edge_n] = $countones(i_dl);
  end

  // Monitor: pop every expectation due at this edge and compare.
  always @(negedge clk) begin
    sb_t         cur;
    logic [31:0] act;
    if (o_busy === 1'b1) busy_total = busy_total + 1;
    while (sb.size() > 0 && sb[0].due <= edge_n) begin
      cur = sb.pop_front();
      case (cur.kind)
        0:       act = o_data & cur.mask;
        1:       act = {31'd0, o_busy};
        default: act = 32'(busy_total - cur.base);
      endcase
      checks = checks + 1;
      if (cur.due != edge_n || act !== cur.exp) begin
        failures = failures + 1;
        $display("FAIL %s: edge %0d (due %0d) got 0x%08h expected 0x%08h",
                 cur.name, edge_n, cur.due, act, cur.exp);
      end
    end
  end

  function automatic logic [127:0] ones_word(input int n);
    logic [127:0] w;
    int           r;
    if (n >= 128) return '1;
    w = (128'(1) << n) - 128'(1);
    r = $urandom_range(127, 0);
    return (w << r) | (w >> (128 - r));
  endfunction

  task automatic push(input string nm, input int due, input int kind,
                      input logic [31:0] exp, input logic [31:0] mask);
    sb_t e;
    int  i;
    e.name = nm; e.due = due; e.kind = kind; e.exp = exp; e.mask = mask;
    e.base = busy_total;
    i = 0;
    while (i < sb.size() && sb[i].due <= due) i++;
    sb.insert(i, e);
  endtask

  task automatic apply();
    i_ctrl = {22'd0, sel_v, k_v, 1'b0, clr_v, start_v, 1'($urandom)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (dl_mode)
      1: i_dl = ones_word(dl_n);
      2: begin alt_ph = ~alt_ph; i_dl = ones_word(alt_ph ? 20 : 10); end
      3: i_dl = '1;
      default: i_dl = {$urandom, $urandom, $urandom, $urandom};
    endcase
  endtask

  // Select a readback word; it appears on o_data after the next edge.
  task automatic read_sel(input logic [1:0] s, input logic [31:0] exp,
                          input logic [31:0] mask, input string nm);
    sel_v = s;
    apply();
    push(nm, edge_n + 1, 0, exp, mask);
    tick();
  endtask

  task automatic start_run(input int kk, input bit push_end, input bit hold, output int t);
    int n;
    n = 1 << kk;
    k_v = 4'(kk);
    start_v = 1'b1;
    apply();
    t = edge_n + 1;
    push("busy_pre", edge_n, 1, 32'd0, '1);
    push("busy_first", t, 1, 32'd1, '1);
    if (push_end) begin
      push("busy_last", t + n + 1, 1, 32'd1, '1);
      push("busy_end", t + n + 2, 1, 32'd0, '1);
      push("busy_cycles", t + n + 3, 2, 32'(n + 2), '1);
    end
    tick();
    if (!hold) begin
      start_v = 1'b0;
      apply();
    end
  endtask

  task automatic wait_done(input int t, input int kk);
    while (edge_n < t + 2 + (1 << kk)) tick();
  endtask

  // Reference: statistics of the window of samples taken at edges t+1 .. t+2^k.
  task automatic check_results(input int t, input int kk, input string tag);
    int n, mn, mx, sm, v;
    n = 1 << kk;
    mn = 1 << 30; mx = -1; sm = 0;
    for (int i = t + 1; i <= t + n; i++) begin
      v  = samp[i];
      sm = sm + v;
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    read_sel(2'd1, {8'd0, 8'(mn), 8'd0, 8'(mx)}, '1, {tag, ".minmax"});
    read_sel(2'd2, 32'(sm), '1, {tag, ".sum"});
    read_sel(2'd3, 32'(n), '1, {tag, ".count"});
    read_sel(2'd0, {2'd3, 6'd0, 8'(sm >> kk), 8'd0, 8'(samp[edge_n - 1])}, '1, {tag, ".status"});
  endtask

  task automatic check_cleared(input string tag);
    read_sel(2'd1, 32'd0, '1, {tag, ".minmax"});
    read_sel(2'd2, 32'd0, '1, {tag, ".sum"});
    read_sel(2'd3, 32'd0, '1, {tag, ".count"});
    read_sel(2'd0, 32'd0, 32'hC000_0000, {tag, ".state"});
  endtask

  initial begin
    int t, t2, c;

    // Reset with random taps.
    i_rst = 1'b0;
    i_dl = {$urandom, $urandom, $urandom, $urandom};
    apply();
    push("rst.data1", 1, 0, 32'd0, '1);
    push("rst.busy1", 1, 1, 32'd0, '1);
    push("rst.data2", 2, 0, 32'd0, '1);
    push("rst.busy2", 2, 1, 32'd0, '1);
    tick(); tick();
    i_rst = 1'b1;
    push("rst.data3", 3, 0, 32'd0, '1);
    push("rst.busy3", 3, 1, 32'd0, '1);
    tick();
    read_sel(2'd0, 32'd0, 32'hC000_0000, "rst.state");

    // Constant 40 taps, k=4.
    dl_mode = 1; dl_n = 40;
    tick();
    start_run(4, 1'b1, 1'b0, t);
    wait_done(t, 4);
    read_sel(2'd1, 32'h0028_0028, '1, "const.minmax");
    read_sel(2'd2, 32'h0000_0280, '1, "const.sum");
    read_sel(2'd3, 32'h0000_0010, '1, "const.count");
    read_sel(2'd0, {2'd3, 6'd0, 8'd40, 8'd0, 8'd40}, '1, "const.status");

    // Alternating 10/20 taps, k=2.
    dl_mode = 2;
    tick();
    start_run(2, 1'b1, 1'b0, t);
    wait_done(t, 2);
    check_results(t, 2, "alt");

    // Random windows including the single-sample case.
    dl_mode = 0;
    start_run(0, 1'b1, 1'b0, t);
    wait_done(t, 0);
    check_results(t, 0, "rnd_k0");
    for (int r = 0; r < 3; r++) begin
      int kk;
      kk = $urandom_range(7, 1);
      start_run(kk, 1'b1, 1'b0, t);
      wait_done(t, kk);
      check_results(t, kk, "rnd");
    end

    // Start held high for 50 cycles gives one run.
    start_run(3, 1'b1, 1'b1, t);
    repeat (50) tick();
    check_results(t, 3, "hold");
    start_v = 1'b0;
    apply();
    tick();

    // Second start pulse during RUN is ignored.
    start_run(5, 1'b1, 1'b0, t);
    while (edge_n < t + 9) tick();
    start_v = 1'b1; apply(); tick();
    start_v = 1'b0; apply();
    wait_done(t, 5);
    check_results(t, 5, "restart_ign");

    // Start in DONE re-arms with fresh min.
    dl_mode = 1; dl_n = 100;
    tick();
    start_run(1, 1'b1, 1'b0, t2);
    wait_done(t2, 1);
    check_results(t2, 1, "rearm");
    read_sel(2'd1, 32'h0064_0064, '1, "rearm.const");

    // Clear mid-RUN.
    dl_mode = 0;
    start_run(6, 1'b0, 1'b0, t);
    while (edge_n < t + 10) tick();
    clr_v = 1'b1; apply();
    c = edge_n + 1;
    push("clr.busy_before", edge_n, 1, 32'd1, '1);
    push("clr.busy_after", c, 1, 32'd0, '1);
    tick();
    clr_v = 1'b0; apply();
    check_cleared("clr");

    // Reset mid-RUN.
    start_run(6, 1'b0, 1'b0, t);
    while (edge_n < t + 10) tick();
    i_rst = 1'b0;
    c = edge_n + 1;
    push("rstrun.busy_before", edge_n, 1, 32'd1, '1);
    push("rstrun.busy_after", c, 1, 32'd0, '1);
    push("rstrun.data", c, 0, 32'd0, '1);
    tick();
    i_rst = 1'b1;
    check_cleared("rstrun");

    // Saturation: all ones, largest window.
    dl_mode = 3;
    tick();
    start_run(15, 1'b1, 1'b0, t);
    wait_done(t, 15);
    read_sel(2'd2, 32'h0040_0000, '1, "sat.sum");
    read_sel(2'd3, 32'h0000_8000, '1, "sat.count");
    read_sel(2'd1, 32'h0080_0080, '1, "sat.minmax");
    read_sel(2'd0, {2'd3, 6'd0, 8'd128, 8'd0, 8'd128}, '1, "sat.status");

    repeat (4) tick();
    checks = checks + 1;
    if (sb.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
